mem_uncache_unit: RTL and testbench
===================================

Name: mem_uncache_unit

Overview:
- Responder for the MEM-stage memory request record (mem_cache_struct). Serves uncached loads and stores by converting each record into one transaction on the core's cache-side bus (rd_req/ret, wr_req/wr_rdy).
- Sits between the MEM stage and the AXI bridge, in parallel with the dcache.
- Single outstanding request at a time. Returns load data or store completion to MEM, and honours pipeline flush.

Parameters:
- ADDR_WIDTH, 32, request/bus address width
- DATA_WIDTH, 32, data width (one word per transaction)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request present
- req_i  in  77  mem_cache_struct {we, ce, sel[3:0], addr, data, uncache_en, rd_type[2:0], wr_type[2:0]}
- req_ready_o  out  1  request accepted this cycle
- flush_i  in  1  pipeline flush
- resp_valid_o  out  1  one-cycle completion pulse
- resp_data_o  out  32  raw load word (0 for stores)
- rd_req_o  out  1  bus read request
- rd_type_o  out  3  read size code (from req rd_type)
- rd_addr_o  out  32  read address
- rd_rdy_i  in  1  bus accepts read
- ret_valid_i  in  1  read data beat valid
- ret_last_i  in  1  final beat
- ret_data_i  in  32  read data
- wr_req_o  out  1  bus write request
- wr_type_o  out  3  write size code
- wr_addr_o  out  32  write address
- wr_wstrb_o  out  4  byte strobes (req sel)
- wr_data_o  out  32  write data
- wr_rdy_i  in  1  bus accepts write

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready_o=1. Latched request cleared.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DRAIN, RESP.
- IDLE:
  - req_ready_o=1.
  - Accept when req_valid_i & req.ce & !flush_i. Latch addr/data/sel/types.
  - we=1 -> WR_REQ; we=0 -> RD_REQ.
  - ce=0 requests are consumed: ready high, no transaction, no response.
  - uncache_en is not examined; routing is the caller's job.
- RD_REQ:
  - rd_req_o=1, held stable until the rd_rdy_i handshake.
  - On handshake -> RD_WAIT.
  - flush_i before handshake -> IDLE; nothing issued.
- RD_WAIT:
  - Capture ret_data_i on ret_valid_i.
  - On ret_valid_i & ret_last_i -> RESP.
  - flush_i -> DRAIN.
- DRAIN: swallow beats until ret_valid_i & ret_last_i -> IDLE. No response.
- WR_REQ:
  - wr_req_o=1, outputs held until wr_rdy_i -> RESP.
  - flush_i does not cancel a write (stores arrive committed). Response is suppressed if a flush occurred while in WR_REQ; a sticky kill bit, cleared on IDLE, records this.
- RESP:
  - resp_valid_o=1 for exactly one cycle, unless killed or flush_i is high that cycle.
  - Then -> IDLE.
- Latency:
  - Read: accept -> rd_req next cycle. Response = 1 cycle after the last-beat cycle.
  - Write: response 1 cycle after wr_rdy_i.
- req_ready_o is 0 in every state except IDLE. Back-to-back requests are therefore spaced by at least one IDLE cycle.
- Multi-beat returns (ret_last_i low): only the last beat's data is kept.
- ret_valid_i outside RD_WAIT/DRAIN is ignored.
- Reset mid-transaction returns to IDLE immediately. The bus is expected to be reset by the same rst.

Decomposition:
- Shared package:
  - mem_cache_struct (existing)
  - new uncache_state_t enum
  - bus size code constants: BYTE=3'b000, HALF=3'b001, WORD=3'b010, LINE=3'b100
- No sub-module; one FSM plus a latch register set.

Test Plan:
- Uncached load: req {we=0, ce=1, addr=0x1FD0_0000, rd_type=WORD}. rd_rdy=1 on the cycle after rd_req, ret_data=0xDEADBEEF with ret_last 2 cycles later -> rd_addr_o=0x1FD0_0000, resp_valid_o pulse, resp_data_o=0xDEADBEEF.
- Uncached byte store: {we=1, sel=4'b0100, addr=0x1FE0_01E2, data=0x0000_4100, wr_type=BYTE}, wr_rdy delayed 3 cycles -> wr_req_o/wr_wstrb_o=4'b0100 stable for 3 cycles, then one resp_valid_o with resp_data_o=0.
- Flush in RD_REQ (rd_rdy=0) -> back to IDLE, rd_req_o drops, no resp, req_ready_o=1 next cycle.
- Flush in RD_WAIT, then ret_last beat 0x12345678 -> state goes through DRAIN, no resp_valid_o; a following load returns its own data correctly.
- Flush during WR_REQ -> write still completes on wr_rdy, resp_valid_o stays 0.
- Async rst asserted mid RD_WAIT -> all outputs 0 and req_ready_o=1 without waiting for a clock edge; req with ce=0 afterwards -> no rd_req_o/wr_req_o.

Source files
------------

// File: rtl/mem_uncache_unit_pkg.sv
// Shared types for the uncached memory path: MEM-stage request record, FSM states, bus size codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_uncache_unit_pkg;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    // Bus transfer size codes carried on rd_type/wr_type
    localparam logic [2:0] BYTE = 3'b000;
    localparam logic [2:0] HALF = 3'b001;
    localparam logic [2:0] WORD = 3'b010;
    localparam logic [2:0] LINE = 3'b100;

    // MEM-stage memory request record (77 bits, we is the MSB)
    typedef struct packed {
        logic                  we;
        logic                  ce;
        logic [3:0]            sel;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
        logic                  uncache_en;
        logic [2:0]            rd_type;
        logic [2:0]            wr_type;
    } mem_cache_struct;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DRAIN,
        RESP
    } uncache_state_t;

endpackage

// File: rtl/mem_uncache_unit.sv
// Turns one MEM-stage request into one cache-side bus read or write; single outstanding.
// Latency: read resp 1 cycle after last beat; write resp 1 cycle after wr_rdy.
// Backpressure: req_ready only in IDLE; bus requests held stable until rd_rdy/wr_rdy.
module mem_uncache_unit
    import mem_uncache_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  mem_cache_struct       req_i,
    output logic                  req_ready_o,
    input  logic                  flush_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  rd_req_o,
    output logic [2:0]            rd_type_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic                  rd_rdy_i,
    input  logic                  ret_valid_i,
    input  logic                  ret_last_i,
    input  logic [DATA_WIDTH-1:0] ret_data_i,
    output logic                  wr_req_o,
    output logic [2:0]            wr_type_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [3:0]            wr_wstrb_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic                  wr_rdy_i
);

    uncache_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [3:0]            sel_q;
    logic [2:0]            rd_type_q;
    logic [2:0]            wr_type_q;
    logic                  kill_q;
    logic                  accept;

    // Routing to this unit is decided upstream, so uncache_en is deliberately ignored
    logic unused_route;
    assign unused_route = req_i.uncache_en;

    // ce=0 requests see ready but are never accepted, so they vanish without a bus cycle
    assign accept = (state_q == IDLE) & req_valid_i & req_i.ce & ~flush_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request latch, read data capture (last beat wins) and the store kill flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            data_q    <= '0;
            sel_q     <= '0;
            rd_type_q <= '0;
            wr_type_q <= '0;
            rdata_q   <= '0;
            kill_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= req_i.addr;
                data_q    <= req_i.data;
                sel_q     <= req_i.sel;
                rd_type_q <= req_i.rd_type;
                wr_type_q <= req_i.wr_type;
                rdata_q   <= '0;   // stores report zero data
            end else if (state_q == RD_WAIT && ret_valid_i) begin
                rdata_q <= ret_data_i;
            end
            // A store in flight cannot be cancelled, only its completion hidden
            if (state_q == IDLE)
                kill_q <= 1'b0;
            else if (state_q == WR_REQ && flush_i)
                kill_q <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        rd_req_o     = 1'b0;
        wr_req_o     = 1'b0;
        resp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (accept) state_d = req_i.we ? WR_REQ : RD_REQ;
            end
            RD_REQ: begin
                rd_req_o = 1'b1;
                // A read already handed to the bus must have its beats drained
                if (rd_rdy_i)     state_d = flush_i ? DRAIN : RD_WAIT;
                else if (flush_i) state_d = IDLE;
            end
            RD_WAIT: begin
                if (ret_valid_i && ret_last_i) state_d = flush_i ? IDLE : RESP;
                else if (flush_i)              state_d = DRAIN;
            end
            DRAIN: begin
                if (ret_valid_i && ret_last_i) state_d = IDLE;
            end
            WR_REQ: begin
                wr_req_o = 1'b1;
                if (wr_rdy_i) state_d = RESP;
            end
            RESP: begin
                resp_valid_o = ~kill_q & ~flush_i;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_data_o = resp_valid_o ? rdata_q : '0;
    assign rd_addr_o   = addr_q;
    assign rd_type_o   = rd_type_q;
    assign wr_addr_o   = addr_q;
    assign wr_type_o   = wr_type_q;
    assign wr_wstrb_o  = sel_q;
    assign wr_data_o   = data_q;

endmodule

// File: tb/tb_mem_uncache_unit.sv
module tb_mem_uncache_unit;
    import mem_uncache_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid_i;
    mem_cache_struct req_i;
    logic            req_ready_o;
    logic            flush_i;
    logic            resp_valid_o;
    logic [31:0]     resp_data_o;
    logic            rd_req_o;
    logic [2:0]      rd_type_o;
    logic [31:0]     rd_addr_o;
    logic            rd_rdy_i;
    logic            ret_valid_i;
    logic            ret_last_i;
    logic [31:0]     ret_data_i;
    logic            wr_req_o;
    logic [2:0]      wr_type_o;
    logic [31:0]     wr_addr_o;
    logic [3:0]      wr_wstrb_o;
    logic [31:0]     wr_data_o;
    logic            wr_rdy_i;

    mem_uncache_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_i(req_i), .req_ready_o(req_ready_o),
        .flush_i(flush_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .rd_req_o(rd_req_o), .rd_type_o(rd_type_o), .rd_addr_o(rd_addr_o), .rd_rdy_i(rd_rdy_i),
        .ret_valid_i(ret_valid_i), .ret_last_i(ret_last_i), .ret_data_i(ret_data_i),
        .wr_req_o(wr_req_o), .wr_type_o(wr_type_o), .wr_addr_o(wr_addr_o),
        .wr_wstrb_o(wr_wstrb_o), .wr_data_o(wr_data_o), .wr_rdy_i(wr_rdy_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected completion: data and the cycle it must appear in
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every completion pulse must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && resp_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: got data %h at cycle %0d, expected no response",
                             resp_data_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (resp_data_o !== e.data || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL resp: got data %h at cycle %0d expected data %h at cycle %0d",
                                 resp_data_o, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic bus_idle();
        rd_rdy_i    = 1'b0;
        ret_valid_i = 1'b0;
        ret_last_i  = 1'b0;
        ret_data_i  = '0;
        wr_rdy_i    = 1'b0;
        flush_i     = 1'b0;
    endtask

    // Load. fmode: 0 none, 1 flush before handshake, 2 flush while waiting for data, 3 flush in response cycle
    task automatic do_load(input logic [31:0] addr, input logic [2:0] rtype, input int nbeats,
                           input int rdy_dly, input int gap, input int fmode, input logic [31:0] last_data);
        mem_cache_struct r;
        logic drained;
        exp_t e;
        r.we = 1'b0; r.ce = 1'b1; r.sel = 4'($urandom); r.addr = addr; r.data = $urandom;
        r.uncache_en = 1'($urandom); r.rd_type = rtype; r.wr_type = 3'($urandom);
        @(negedge clk); bus_idle();
        req_i = r; req_valid_i = 1'b1;
        #1 chk("idle_ready", req_ready_o, 1);
        for (int d = 0; d <= rdy_dly; d++) begin
            @(negedge clk); bus_idle();
            req_valid_i = 1'b0;
            if (d == rdy_dly && fmode == 1) flush_i = 1'b1;
            else if (d == rdy_dly) rd_rdy_i = 1'b1;
            else begin
                // stray beats before the read is accepted must be ignored
                ret_valid_i = 1'($urandom); ret_last_i = 1'b1; ret_data_i = $urandom;
            end
            #1;
            chk("rd_req", rd_req_o, 1);
            chk("rd_addr", rd_addr_o, addr);
            chk("rd_type", rd_type_o, rtype);
            chk("busy_ready", req_ready_o, 0);
        end
        if (fmode == 1) begin
            @(negedge clk); bus_idle();
            #1;
            chk("rdflush_rd_req", rd_req_o, 0);
            chk("rdflush_ready", req_ready_o, 1);
            return;
        end
        @(negedge clk); bus_idle();
        drained = 1'b0;
        if (fmode == 2) begin
            flush_i = 1'b1; drained = 1'b1;
            @(negedge clk); bus_idle();
        end
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); bus_idle();
            end
            ret_valid_i = 1'b1;
            ret_last_i  = (b == nbeats - 1);
            ret_data_i  = (b == nbeats - 1) ? last_data : $urandom;
            if (b == nbeats - 1 && !drained && fmode != 3) begin
                e.data = last_data; e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            @(negedge clk); bus_idle();
        end
        if (fmode == 3) flush_i = 1'b1;
        #1 chk("post_load_ready", req_ready_o, {31'd0, drained});
    endtask

    // Store. fat: cycle within the write wait at which flush is pulsed, -1 for none
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                            input logic [2:0] wtype, input int rdy_dly, input int fat);
        mem_cache_struct r;
        exp_t e;
        r.we = 1'b1; r.ce = 1'b1; r.sel = sel; r.addr = addr; r.data = data;
        r.uncache_en = 1'($urandom); r.rd_type = 3'($urandom); r.wr_type = wtype;
        @(negedge clk); bus_idle();
        req_i = r; req_valid_i = 1'b1;
        #1 chk("idle_ready", req_ready_o, 1);
        for (int d = 0; d <= rdy_dly; d++) begin
            @(negedge clk); bus_idle();
            req_valid_i = 1'b0;
            if (d == fat) flush_i = 1'b1;
            if (d == rdy_dly) begin
                wr_rdy_i = 1'b1;
                if (fat < 0) begin
                    e.data = 32'd0; e.cyc = cyc + 1;
                    exp_q.push_back(e);
                end
            end
            #1;
            chk("wr_req", wr_req_o, 1);
            chk("wr_addr", wr_addr_o, addr);
            chk("wr_data", wr_data_o, data);
            chk("wr_wstrb", wr_wstrb_o, sel);
            chk("wr_type", wr_type_o, wtype);
            chk("wr_no_rd_req", rd_req_o, 0);
        end
        @(negedge clk); bus_idle();
        #1 chk("resp_cycle_ready", req_ready_o, 0);
    endtask

    // A request that must not start a transaction (ce=0, or flush in IDLE)
    task automatic do_ignored(input logic ce, input logic flush);
        mem_cache_struct r;
        r.we = 1'($urandom); r.ce = ce; r.sel = 4'($urandom); r.addr = $urandom; r.data = $urandom;
        r.uncache_en = 1'($urandom); r.rd_type = WORD; r.wr_type = WORD;
        @(negedge clk); bus_idle();
        req_i = r; req_valid_i = 1'b1; flush_i = flush;
        #1 chk("ign_ready", req_ready_o, 1);
        @(negedge clk); bus_idle();
        req_valid_i = 1'b0;
        #1;
        chk("ign_rd_req", rd_req_o, 0);
        chk("ign_wr_req", wr_req_o, 0);
        chk("ign_ready_after", req_ready_o, 1);
    endtask

    initial begin
        mem_cache_struct r;
        rst = 1'b1; req_valid_i = 1'b0; req_i = '0; bus_idle();
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_wr_req", wr_req_o, 0);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_load(32'h1FD0_0000, WORD, 1, 1, 1, 0, 32'hDEAD_BEEF);
        do_store(32'h1FE0_01E2, 32'h0000_4100, 4'b0100, BYTE, 2, -1);
        do_load(32'h1FD0_0004, WORD, 1, 2, 0, 1, 32'h0);
        do_load(32'h1FD0_0008, WORD, 1, 0, 1, 2, 32'h1234_5678);
        do_load(32'h1FD0_0010, WORD, 1, 0, 0, 0, 32'hCAFE_F00D);
        do_store(32'h1FE0_0100, 32'hA5A5_5A5A, 4'b1111, WORD, 3, 1);
        do_load(32'h1FD0_0020, HALF, 1, 1, 0, 3, 32'h0BAD_0BAD);
        do_ignored(1'b0, 1'b0);
        do_ignored(1'b1, 1'b1);
        do_load(32'h1FD0_0040, LINE, 4, 0, 1, 0, 32'h7777_1111);

        // Asynchronous reset while waiting for read data
        r = '0; r.ce = 1'b1; r.addr = 32'h1FD0_0080; r.rd_type = WORD;
        @(negedge clk); bus_idle(); req_i = r; req_valid_i = 1'b1;
        @(negedge clk); bus_idle(); req_valid_i = 1'b0; rd_rdy_i = 1'b1;
        @(negedge clk); bus_idle();
        #3 rst = 1'b1;
        #1;
        chk("arst_ready", req_ready_o, 1);
        chk("arst_rd_req", rd_req_o, 0);
        chk("arst_wr_req", wr_req_o, 0);
        chk("arst_resp_valid", resp_valid_o, 0);
        chk("arst_rd_addr", rd_addr_o, 0);
        chk("arst_wr_data", wr_data_o, 0);
        @(negedge clk); rst = 1'b0;
        do_ignored(1'b0, 1'b0);
        do_load(32'h1FD0_0084, WORD, 1, 0, 0, 0, 32'h0000_0042);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int rdy, fm, nb, fat;
            logic [2:0] sz;
            rdy = $urandom_range(0, 3);
            sz  = (i % 3 == 0) ? BYTE : ((i % 3 == 1) ? HALF : WORD);
            if ($urandom_range(0, 1) == 0) begin
                fm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                nb = $urandom_range(1, 3);
                do_load($urandom, sz, nb, rdy, $urandom_range(0, 2), fm, $urandom);
            end else begin
                fat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rdy) : -1;
                do_store($urandom, $urandom, 4'($urandom), sz, rdy, fat);
            end
            if ($urandom_range(0, 7) == 0) do_ignored(1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
